multicycle_controller: RTL
==========================

# multicycle_controller

Control unit for the multicycle RV32I core. A Moore state machine sequences one shared ALU, one unified memory port and the immediate extender across fetch, decode, execute, memory and writeback cycles. It also drives the extender's 3-bit `immsrc` code and the ALU operation select. It sits beside the datapath, reads only opcode/funct fields and the ALU `zero` flag, and drives every enable and mux select.

## Interface
- Parameters: none. Opcode and state encodings are fixed.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 7: `instr[6:0]` from the instruction register.
- `funct3` in 3: `instr[14:12]`.
- `funct7b5` in 1: `instr[30]`.
- `zero` in 1: ALU result-equals-zero flag.
- `pcwrite` out 1: PC register enable.
- `adrsrc` out 1: memory address select. 0 = PC, 1 = result bus.
- `memwrite` out 1: data memory write enable.
- `irwrite` out 1: instruction register and OldPC enable.
- `regwrite` out 1: register file write enable.
- `resultsrc` out 2: result bus select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alusrca` out 2: ALU A select. 00 = PC, 01 = OldPC, 10 = A register.
- `alusrcb` out 2: ALU B select. 00 = B register, 01 = ImmExt, 10 = constant 4.
- `alucontrol` out 3: ALU operation. 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `immsrc` out 3: extender format. 000 I, 001 S, 010 B, 011 J.

## Operation
- Opcode classes:
  - lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, jal 1101111, beq 1100011.
  - Any other opcode is "undefined".
- States and transitions:
  - FETCH → DECODE.
  - DECODE → MEMADR for lw/sw, EXECR for R, EXECI for I-ALU, JAL for jal, BEQ for beq, FETCH for undefined.
  - MEMADR → MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD → MEMWB → FETCH.
  - MEMWRITE → FETCH.
  - EXECR → ALUWB; EXECI → ALUWB; JAL → ALUWB.
  - ALUWB → FETCH.
  - BEQ → FETCH.
- Moore outputs per state. Any signal not listed is 0 / 00.
  - FETCH: irwrite=1, alusrcb=10, resultsrc=10, pcupdate=1, aluop=00.
  - DECODE: alusrca=01, alusrcb=01, aluop=00. Precomputes the branch/jump target.
  - MEMADR: alusrca=10, alusrcb=01, aluop=00.
  - MEMREAD: adrsrc=1, resultsrc=00.
  - MEMWB: resultsrc=01, regwrite=1.
  - MEMWRITE: adrsrc=1, resultsrc=00, memwrite=1.
  - EXECR: alusrca=10, alusrcb=00, aluop=10.
  - EXECI: alusrca=10, alusrcb=01, aluop=10.
  - ALUWB: resultsrc=00, regwrite=1.
  - JAL: alusrca=01, alusrcb=10, resultsrc=00, pcupdate=1, aluop=00.
  - BEQ: alusrca=10, alusrcb=00, resultsrc=00, branch=1, aluop=01.
- `pcwrite` = pcupdate | (branch & zero).
- `beq` only: `funct3` is ignored in the BEQ state.
- `immsrc` is combinational from `op` alone, in every state:
  - 000 for lw and I-ALU.
  - 001 for sw.
  - 010 for beq.
  - 011 for jal.
  - 000 for undefined opcodes.
- `alucontrol` is combinational from the internal aluop:
  - aluop 00 → add.
  - aluop 01 → sub.
  - aluop 10, funct3 000 → sub if op[5] & funct7b5, else add. I-type addi with instr[30]=1 is therefore add.
  - aluop 10, funct3 010 → slt.
  - aluop 10, funct3 110 → or.
  - aluop 10, funct3 111 → and.
  - aluop 10, any other funct3 → add.

## Timing
- Reset:
  - `reset` high at a rising edge loads FETCH, including mid-instruction. Any in-flight instruction is abandoned with no further writes.
  - While `reset` is high, `pcwrite`, `irwrite`, `memwrite` and `regwrite` are forced to 0 combinationally.
  - While `reset` is high, selects show the current state's decode. After the first reset edge that is FETCH values: adrsrc=0, alusrca=00, alusrcb=10, resultsrc=10, alucontrol=000.
- Cycles per instruction, counted from the FETCH cycle:
  - lw 5, sw 4, R 4, I-ALU 4, jal 4, beq 3, undefined 2.
- Undefined opcode: no write enable asserts in DECODE. The following FETCH asserts pcwrite, so PC advances by 4.
- `zero` is sampled only combinationally in BEQ. A taken branch writes PC in that same cycle.
- `op` and `funct` fields are assumed stable from DECODE through writeback; the instruction register only updates in FETCH.

## Test plan
- Reset: hold reset 3 cycles mid-MEMREAD. Required: all four write enables 0 while reset is high; state FETCH on release; irwrite=1 and pcwrite=1 in the first post-reset cycle.
- lw, op=0000011:
  - Enable trace: irwrite in cycle 0; nothing in cycles 1–3; regwrite in cycle 4 with resultsrc=01.
  - adrsrc=1 in cycle 3 only.
  - immsrc=000 throughout.
- sw, op=0100011: memwrite=1 only in cycle 3 with adrsrc=1; immsrc=001; regwrite never asserts.
- R-type funct3=000:
  - funct7b5=1 → alucontrol=001 in EXECR.
  - funct7b5=0 → 000.
  - funct3=110 → 011.
  - funct3=010 → 101.
  - regwrite asserts in cycle 3.
- beq, op=1100011: immsrc=010; cycle 2 alucontrol=001. zero=1 → pcwrite=1 in cycle 2; zero=0 → pcwrite=0. Next cycle is FETCH.
- jal, op=1101111: immsrc=011; JAL state pcwrite=1, alusrca=01, alusrcb=10; ALUWB regwrite=1 with resultsrc=00. Undefined op=1111111 returns to FETCH after 2 cycles with no writes.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control unit for a multicycle RV32I core: a Moore FSM that sequences the
// shared ALU, unified memory port and immediate extender, plus combinational
// immediate-format and ALU-operation decoders.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [2:0] immsrc
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_JAL      = 4'd8,
    S_BEQ      = 4'd9,
    S_ALUWB    = 4'd10
  } state_t;

  state_t     state_q, state_d;
  logic       pcupdate, branch;
  logic       memwrite_raw, irwrite_raw, regwrite_raw;
  logic [1:0] aluop;

  // State register; reset abandons any in-flight instruction.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic and per-state Moore outputs.
  always_comb begin
    state_d      = S_FETCH;
    pcupdate     = 1'b0;
    branch       = 1'b0;
    adrsrc       = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    resultsrc    = 2'b00;
    alusrca      = 2'b00;
    alusrcb      = 2'b00;
    aluop        = 2'b00;
    case (state_q)
      S_FETCH: begin
        irwrite_raw = 1'b1;
        alusrcb     = 2'b10;
        resultsrc   = 2'b10;
        pcupdate    = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes OldPC + imm as the branch/jump target.
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrsrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc    = 2'b01;
        regwrite_raw = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc       = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_EXECR: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_JAL: begin
        // ALU forms OldPC + 4 as the link value while PC takes the target.
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
        state_d  = S_ALUWB;
      end
      S_BEQ: begin
        alusrca = 2'b10;
        branch  = 1'b1;
        aluop   = 2'b01;
      end
      S_ALUWB: begin
        regwrite_raw = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write enables are gated by reset so nothing commits while it is held.
  always_comb begin
    pcwrite  = (pcupdate | (branch & zero)) & ~reset;
    memwrite = memwrite_raw & ~reset;
    irwrite  = irwrite_raw & ~reset;
    regwrite = regwrite_raw & ~reset;
  end

  // Immediate format depends only on the opcode.
  always_comb begin
    case (op)
      OP_SW:   immsrc = 3'b001;
      OP_BEQ:  immsrc = 3'b010;
      OP_JAL:  immsrc = 3'b011;
      default: immsrc = 3'b000;
    endcase
  end

  // ALU decoder; subtract for funct3=000 only on R-type with instr[30] set.
  always_comb begin
    case (aluop)
      2'b00: alucontrol = 3'b000;
      2'b01: alucontrol = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

endmodule
